pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic pipeline-stage register for the pipelined RISC-V core, the successor to the fixed MEM/WB latch. It carries a packed datapath word plus a separately handled control field between two stages through a valid/ready handshake and up to DEPTH entries of buffering. Control bits are forced to zero whenever the output holds no valid entry, so downstream stages see a bubble, never a stale write-enable. It supports synchronous flush for branch/exception squash. It is instantiated between EX/MEM and MEM/WB, and at any stage boundary that needs backpressure.

## Interface
Parameters:
- DATA_W, default 69: datapath payload width (e.g. ALU result 32 + load data 32 + rd 5).
- CTRL_W, default 2: control payload width (e.g. RegWrite, MemToReg); zeroed on bubbles.
- DEPTH, default 2: number of storage entries, legal range 1..8.
- CNT_W, default $clog2(DEPTH+1): width of the level output.

Ports:
- clk, in, 1: clock, all state updates on rising edge.
- rst, in, 1: reset, synchronous, active-low.
- flush, in, 1: synchronous squash of all held entries.
- in_valid, in, 1: upstream presents an entry.
- in_ready, out, 1: stage can accept an entry this cycle.
- in_data, in, DATA_W: upstream datapath payload.
- in_ctrl, in, CTRL_W: upstream control payload.
- out_valid, out, 1: head entry valid.
- out_ready, in, 1: downstream consumes the head entry this cycle.
- out_data, out, DATA_W: head datapath payload.
- out_ctrl, out, CTRL_W: head control payload, or all-zero when out_valid=0.
- level, out, CNT_W: number of entries currently held.

## Operation
- Storage is a circular buffer of DEPTH entries with write pointer wp, read pointer rp, and counter cnt.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (cnt != DEPTH). It depends only on registered state, with no combinational path from out_ready.
- out_valid = (cnt != 0).
- out_data = mem_data[rp].
- out_ctrl = out_valid ? mem_ctrl[rp] : 0.
- level = cnt.
- Push writes in_data/in_ctrl at wp; wp advances, wrapping from DEPTH-1 to 0.
- Pop advances rp with the same wrap.
- cnt update: push only → +1; pop only → −1; push and pop in the same cycle → unchanged.
- Full with out_ready=1: in_ready is still 0, so there is no same-cycle push. The freed slot is offered the next cycle.
- Empty: pop is impossible because out_valid=0.
- flush=1: next cycle cnt=0 and wp=rp=0. A push or pop in the same cycle is discarded. Storage contents are not cleared.
- Priority, highest first: rst, then flush, then push/pop.
- DEPTH=1: the stage behaves as a plain register with half throughput under continuous streaming (accept, drain, accept). This is acceptable for non-critical boundaries.
- in_valid while in_ready=0: the entry is not taken. Upstream must hold it; the stage does not check this.

## Timing
- Reset (rst=0 at a rising edge): cnt=0, wp=0, rp=0, all mem_data/mem_ctrl entries = 0.
- Outputs after reset: out_valid=0, out_data=0, out_ctrl=0, level=0, in_ready=1.
- Reset asserted mid-stream drops all entries. The first post-reset cycle shows the values above.
- Latency: an entry pushed at edge N is visible at out_* from edge N (registered output) with out_valid=1. That is one cycle from in_valid&in_ready to out_valid.
- Throughput for DEPTH≥2: one entry per cycle sustained with out_ready=1.
- A level change is visible the cycle after the push/pop edge.
- Flush asserted at edge N: out_valid=0, out_ctrl=0, level=0 after edge N; in_ready=1.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1, in_ctrl=2'b11 → out_valid=0, out_ctrl=0, out_data=0, level=0, in_ready=1; release → first push of data 0x1_2345_6789 is seen on out_data next cycle.
- Streaming, DEPTH=2: push 0..9 back-to-back with out_ready=1 → outputs 0..9 in order, one per cycle, 1-cycle latency, level stays 1, in_ready never drops.
- Backpressure: out_ready=0, push A, B → level=2, in_ready=0; C is held on input; raise out_ready → A, B, C appear in order with no loss or duplication, and wrap-around of wp/rp is exercised.
- Bubble control: empty stage with out_ready=1 and a previous entry ctrl=2'b11 drained → out_ctrl=2'b00 while out_valid=0; out_data holds the last value.
- Flush: level=2, assert flush together with in_valid=1 and out_ready=1 → next cycle level=0, out_valid=0, and the pushed entry is never emitted.
- DEPTH=1 parameter sweep: continuous in_valid with out_ready=1 → accepts every other cycle; order preserved; in_ready = !out_valid.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: DEPTH-entry circular buffer with valid/ready
// handshake, synchronous flush, and control bits zeroed on bubbles.

module pipe_stage_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst)      q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module pipe_stage_buf #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  level
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;
  logic [DEPTH-1:0] we;
  ent_t             wr_ent, head;
  ent_t             ent_q [DEPTH];

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr_ent    = '{data: in_data, ctrl: in_ctrl};

  // Squashed pushes never touch storage.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      assign we[g] = push & ~flush & (wp_q == PW'(g));
      pipe_stage_entry #(.W($bits(ent_t))) u_ent (
        .clk  (clk),
        .rst  (rst),
        .we_i (we[g]),
        .d_i  (wr_ent),
        .q_o  (ent_q[g])
      );
    end
  endgenerate

  always_comb begin
    head = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rp_q == PW'(i)) head = ent_q[i];
  end

  assign out_data = head.data;
  assign out_ctrl = out_valid ? head.ctrl : '0;
  assign level    = cnt_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = ptr_nxt(wp_q);
      if (pop)  rp_d = ptr_nxt(rp_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=2 instance for the main function,
// DEPTH=1 instance for the half-throughput register mode.

module tb_pipe_stage_buf;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [68:0] in_data;
  logic [1:0]  in_ctrl;

  logic        a_in_ready, a_out_valid;
  logic [68:0] a_out_data;
  logic [1:0]  a_out_ctrl, a_level;

  logic        b_in_ready, b_out_valid;
  logic [68:0] b_out_data;
  logic [1:0]  b_out_ctrl;
  logic        b_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(69), .CTRL_W(2), .DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .level(a_level)
  );

  pipe_stage_buf #(.DATA_W(69), .CTRL_W(2), .DEPTH(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .level(b_level)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 2'b11;
    in_data = 69'h1F_DEAD_BEEF; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_ctrl",  a_out_ctrl,  0);
    chk("rst_out_data",  a_out_data,  0);
    chk("rst_level",     a_level,     0);
    chk("rst_in_ready",  a_in_ready,  1);

    // first push after release
    rst = 1'b1; in_data = 69'h1_2345_6789; in_ctrl = 2'b01;
    tick();
    chk("first_valid", a_out_valid, 1);
    chk("first_data",  a_out_data,  69'h1_2345_6789);
    chk("first_ctrl",  a_out_ctrl,  2'b01);
    chk("first_level", a_level,     1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain_level", a_level,     0);
    chk("drain_valid", a_out_valid, 0);

    // back-to-back streaming, one cycle latency
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = 69'(k); in_ctrl = 2'(k);
      tick();
      chk("strm_valid", a_out_valid, 1);
      chk("strm_data",  a_out_data,  k);
      chk("strm_level", a_level,     1);
      chk("strm_ready", a_in_ready,  1);
    end
    in_valid = 1'b0;
    tick();
    chk("strm_end_level", a_level, 0);

    // backpressure: A, B fill, C held on input
    out_ready = 1'b0; in_valid = 1'b1; in_data = 69'hA; in_ctrl = 2'b01;
    tick();
    chk("bp_lvl_a", a_level, 1);
    in_data = 69'hB; in_ctrl = 2'b10;
    tick();
    chk("bp_lvl_ab",  a_level,    2);
    chk("bp_full_rd", a_in_ready, 0);
    in_data = 69'hC; in_ctrl = 2'b11;
    tick();
    chk("bp_hold_lvl",  a_level,    2);
    chk("bp_hold_head", a_out_data, 69'hA);
    chk("bp_hold_ctrl", a_out_ctrl, 2'b01);
    out_ready = 1'b1;
    tick();
    chk("bp_pop_a_lvl", a_level,    1);
    chk("bp_head_b",    a_out_data, 69'hB);
    chk("bp_ctrl_b",    a_out_ctrl, 2'b10);
    tick();
    chk("bp_swap_lvl", a_level,    1);
    chk("bp_head_c",   a_out_data, 69'hC);
    chk("bp_ctrl_c",   a_out_ctrl, 2'b11);
    in_valid = 1'b0;
    tick();
    chk("bub_valid", a_out_valid, 0);
    chk("bub_ctrl",  a_out_ctrl,  0);
    chk("bub_level", a_level,     0);

    // flush with a simultaneous push and pop
    out_ready = 1'b0; in_valid = 1'b1; in_data = 69'hD; in_ctrl = 2'b01;
    tick();
    in_data = 69'hE;
    tick();
    chk("fl_pre_lvl", a_level, 2);
    flush = 1'b1; out_ready = 1'b1; in_data = 69'hF; in_ctrl = 2'b11;
    tick();
    chk("fl_level", a_level,     0);
    chk("fl_valid", a_out_valid, 0);
    chk("fl_ctrl",  a_out_ctrl,  0);
    chk("fl_ready", a_in_ready,  1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl_no_emit", a_out_valid, 0);
    in_valid = 1'b1; in_data = 69'h77; in_ctrl = 2'b10; out_ready = 1'b0;
    tick();
    chk("fl_post_data", a_out_data, 69'h77);
    chk("fl_post_lvl",  a_level,    1);

    // reset mid-stream drops entries and clears storage
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("mrst_level", a_level,     0);
    chk("mrst_valid", a_out_valid, 0);
    chk("mrst_data",  a_out_data,  0);
    rst = 1'b1;
    tick();

    // DEPTH=1: accept on even cycles, drain on odd
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 2'b01;
    for (int i = 0; i < 10; i++) begin
      in_data = 69'((i + 1) / 2);
      tick();
      chk("d1_valid", b_out_valid, (i % 2 == 0));
      chk("d1_ready", b_in_ready,  (i % 2 == 1));
      if (i % 2 == 0) chk("d1_data", b_out_data, i / 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
